fns_seq_decoder: RTL and testbench

- Receiver-side counterpart of the FNS/DPS encoder stages.
- Takes one CW-bit Fibonacci-numeral-system (FNS) codeword, decodes it serially (one code bit per cycle, MSB first) and returns the binary data value.
- Uses valid/ready handshakes on both sides.
- Sits directly downstream of the CAC bus receive registers, and ahead of the data-block reassembly logic.

---
 rtl/fns_seq_decoder.sv | 155 +++++++++++++++
 tb/tb_fns_seq_decoder.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fns_seq_decoder.sv
// Serial Fibonacci-numeral-system decoder: accepts one CW-bit codeword, walks it MSB first
// (one bit per cycle) accumulating weights, and presents the binary value with a range flag.
module fns_seq_decoder #(
    parameter int unsigned CW     = 8,   // codeword width, 3..16
    parameter int unsigned DW     = 6,   // 2**DW must exceed the sum of all weights
    parameter int unsigned MAXVAL = 54   // largest value decoded without range_err
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] codein,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] dataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          range_err,
    output logic          busy
);

    // W(0)=W(1)=1, W(i)=W(i-1)+W(i-2), evaluated at elaboration time.
    function automatic int unsigned fib_weight(input int unsigned idx);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 1;
        b = 1;
        for (int unsigned i = 2; i <= idx; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    localparam int unsigned     CntW    = $clog2(CW);
    localparam logic [DW-1:0]   WHi     = DW'(fib_weight(CW - 1));
    localparam logic [DW-1:0]   WLo     = DW'(fib_weight(CW - 2));
    localparam logic [CntW-1:0] LastCnt = CntW'(CW - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   shreg_q, shreg_d;
    logic [DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   dataout_q, dataout_d;
    logic            range_err_q, range_err_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;

    logic [DW-1:0]   sum;

    // Running sum including the bit currently at the MSB of the shift register.
    assign sum = acc_q + (shreg_q[CW-1] ? hi_q : '0);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        dataout_d   = dataout_q;
        range_err_d = range_err_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d    = codein;
                    acc_d      = '0;
                    hi_d       = WHi;
                    lo_d       = WLo;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StAcc;
                end
            end
            StAcc: begin
                acc_d   = sum;
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    dataout_d   = sum;
                    range_err_d = (32'(sum) > MAXVAL);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StDone;
                end else begin
                    // Weight pair steps down the Fibonacci ladder; frozen on the last bit.
                    hi_d = lo_q;
                    lo_d = hi_q - lo_q;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            acc_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            dataout_q   <= '0;
            range_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            dataout_q   <= dataout_d;
            range_err_q <= range_err_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign dataout   = dataout_q;
    assign out_valid = out_valid_q;
    assign range_err = range_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fns_seq_decoder.sv
// Bench for fns_seq_decoder: three instances (CW=8/MAXVAL=54, CW=8/MAXVAL=33, CW=4/MAXVAL=7)
// checked against a weighted-sum model of the Fibonacci numeral system.
module tb_fns_seq_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] in_valid_v;
    logic [2:0] out_ready_v;
    wire  [2:0] in_ready_v;
    wire  [2:0] out_valid_v;
    wire  [2:0] range_err_v;
    wire  [2:0] busy_v;
    logic [7:0] code_a;
    logic [7:0] code_b;
    logic [3:0] code_c;
    wire  [5:0] dout_a;
    wire  [5:0] dout_b;
    wire  [2:0] dout_c;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    fns_seq_decoder #(.CW(8), .DW(6), .MAXVAL(54)) u_dut_a (
        .clock(clock), .reset(reset), .codein(code_a), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .dataout(dout_a), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .range_err(range_err_v[0]), .busy(busy_v[0])
    );

    fns_seq_decoder #(.CW(8), .DW(6), .MAXVAL(33)) u_dut_b (
        .clock(clock), .reset(reset), .codein(code_b), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .dataout(dout_b), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .range_err(range_err_v[1]), .busy(busy_v[1])
    );

    fns_seq_decoder #(.CW(4), .DW(3), .MAXVAL(7)) u_dut_c (
        .clock(clock), .reset(reset), .codein(code_c), .in_valid(in_valid_v[2]),
        .in_ready(in_ready_v[2]), .dataout(dout_c), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .range_err(range_err_v[2]), .busy(busy_v[2])
    );

    // Reference: value = sum of Fibonacci weights of the set bits.
    function automatic int fns_value(input int cw, input logic [15:0] code);
        int w[16];
        int s;
        w[0] = 1;
        w[1] = 1;
        for (int i = 2; i < 16; i++) w[i] = w[i-1] + w[i-2];
        s = 0;
        for (int i = 0; i < cw; i++) if (code[i]) s += w[i];
        return s;
    endfunction

    function automatic int dout_of(input int which);
        case (which)
            0:       return int'(dout_a);
            1:       return int'(dout_b);
            default: return int'(dout_c);
        endcase
    endfunction

    task automatic set_code(input int which, input logic [15:0] code);
        case (which)
            0:       code_a = code[7:0];
            1:       code_b = code[7:0];
            default: code_c = code[3:0];
        endcase
    endtask

    task automatic wait_ready(input int which, output bit ok);
        int n;
        n = 0;
        while (!in_ready_v[which] && n < 30) begin
            @(posedge clock); #1;
            n++;
        end
        ok = in_ready_v[which];
    endtask

    // One full transaction: accept, count cycles to out_valid, stall, sample, handshake.
    task automatic xfer(input int which, input logic [15:0] code, input int stall,
                        output int data, output logic rerr, output int lat, output bit ok);
        data = -1;
        rerr = 1'bx;
        lat  = -1;
        wait_ready(which, ok);
        if (!ok) return;
        set_code(which, code);
        in_valid_v[which] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[which] = 1'b0;
        lat = 0;
        while (!out_valid_v[which] && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid_v[which]) begin
            ok = 1'b0;
            return;
        end
        repeat (stall) begin
            @(posedge clock); #1;
        end
        data = dout_of(which);
        rerr = range_err_v[which];
        out_ready_v[which] = 1'b1;
        @(posedge clock); #1;
        out_ready_v[which] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int w = 0; w < 3; w++) begin
            vectors += 5;
            if (in_ready_v[w] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready dut%0d got %b want 1", w, in_ready_v[w]);
            end
            if (out_valid_v[w] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out_valid dut%0d got %b want 0", w, out_valid_v[w]);
            end
            if (busy_v[w] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_busy dut%0d got %b want 0", w, busy_v[w]);
            end
            if (range_err_v[w] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_range_err dut%0d got %b want 0", w, range_err_v[w]);
            end
            if (dout_of(w) !== 0) begin
                miscompares++;
                $display("FAIL reset_dataout dut%0d got %0d want 0", w, dout_of(w));
            end
        end
    endtask

    task automatic test_decode;
        logic [7:0] codes[4] = '{8'b00000000, 8'b11111111, 8'b10000001, 8'b01010101};
        int         want[4]  = '{0, 54, 22, 21};
        int data, lat;
        logic rerr;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            xfer(0, {8'h00, codes[i]}, 0, data, rerr, lat, ok);
            vectors += 4;
            if (!ok) begin
                miscompares++;
                $display("FAIL decode_timeout code %b got no output want output", codes[i]);
            end
            if (data !== want[i]) begin
                miscompares++;
                $display("FAIL decode_value code %b got %0d want %0d", codes[i], data, want[i]);
            end
            if (lat !== 8) begin
                miscompares++;
                $display("FAIL decode_latency code %b got %0d want 8", codes[i], lat);
            end
            if (rerr !== 1'b0) begin
                miscompares++;
                $display("FAIL decode_range_err code %b got %b want 0", codes[i], rerr);
            end
        end
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (dout_a !== 6'd21) begin
            miscompares++;
            $display("FAIL dataout_hold got %0d want 21", dout_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w1, w2;
        int acc2, v1, v2, ov_cnt;
        bit ir_bad, ok;
        w1 = 8'b00100000;
        w2 = 8'b00000110;
        acc2 = -1; v1 = -1; v2 = -1; ov_cnt = 0; ir_bad = 1'b0;
        wait_ready(0, ok);
        code_a = w1;
        in_valid_v[0] = 1'b1;
        out_ready_v[0] = 1'b1;
        @(posedge clock); #1;
        code_a = w2;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (k == 10) in_valid_v[0] = 1'b0;
            if (in_ready_v[0] && (k <= 8 || (k >= 10 && k <= 18))) ir_bad = 1'b1;
            if (in_ready_v[0] && acc2 < 0) acc2 = k + 1;
            if (out_valid_v[0]) begin
                if (ov_cnt == 0) v1 = int'(dout_a);
                else if (ov_cnt == 1) v2 = int'(dout_a);
                ov_cnt++;
            end
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b0;
        vectors += 5;
        if (acc2 !== 10) begin
            miscompares++;
            $display("FAIL b2b_second_accept got edge %0d want 10", acc2);
        end
        if (v1 !== fns_value(8, {8'h00, w1})) begin
            miscompares++;
            $display("FAIL b2b_first got %0d want %0d", v1, fns_value(8, {8'h00, w1}));
        end
        if (v2 !== fns_value(8, {8'h00, w2})) begin
            miscompares++;
            $display("FAIL b2b_second got %0d want %0d", v2, fns_value(8, {8'h00, w2}));
        end
        if (ir_bad !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_in_ready got high during ACC/DONE want low");
        end
        if (ov_cnt !== 2) begin
            miscompares++;
            $display("FAIL b2b_out_count got %0d want 2", ov_cnt);
        end
    endtask

    task automatic test_backpressure;
        int want, lat;
        bit ok;
        want = fns_value(8, 16'h0090);
        wait_ready(0, ok);
        code_a = 8'b10010000;
        in_valid_v[0] = 1'b1;
        out_ready_v[0] = 1'b0;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (!out_valid_v[0] && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        vectors++;
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL bp_latency got %0d want 8", lat);
        end
        for (int i = 0; i < 6; i++) begin
            vectors += 2;
            if (out_valid_v[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_out_valid cycle %0d got %b want 1", i, out_valid_v[0]);
            end
            if (int'(dout_a) !== want) begin
                miscompares++;
                $display("FAIL bp_dataout cycle %0d got %0d want %0d", i, dout_a, want);
            end
            @(posedge clock); #1;
        end
        out_ready_v[0] = 1'b1;
        @(posedge clock); #1;
        out_ready_v[0] = 1'b0;
        vectors += 2;
        if (out_valid_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release_valid got %b want 0", out_valid_v[0]);
        end
        if (in_ready_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready got %b want 1", in_ready_v[0]);
        end
        @(posedge clock); #1;
        vectors++;
        if (out_valid_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_single_handshake got %b want 0", out_valid_v[0]);
        end
    endtask

    task automatic test_range;
        logic [7:0] codes[2] = '{8'b10100000, 8'b11000000};
        int         want[2]  = '{29, 34};
        logic       werr[2]  = '{1'b0, 1'b1};
        logic [7:0] c;
        int data, lat, m;
        logic rerr;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            xfer(1, {8'h00, codes[i]}, 0, data, rerr, lat, ok);
            vectors += 2;
            if (data !== want[i]) begin
                miscompares++;
                $display("FAIL range_value code %b got %0d want %0d", codes[i], data, want[i]);
            end
            if (rerr !== werr[i]) begin
                miscompares++;
                $display("FAIL range_flag code %b got %b want %b", codes[i], rerr, werr[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            c = 8'($urandom_range(0, 255));
            m = fns_value(8, {8'h00, c});
            xfer(1, {8'h00, c}, int'($urandom_range(0, 2)), data, rerr, lat, ok);
            vectors += 2;
            if (data !== m) begin
                miscompares++;
                $display("FAIL range_rand_value code %b got %0d want %0d", c, data, m);
            end
            if (rerr !== (m > 33)) begin
                miscompares++;
                $display("FAIL range_rand_flag code %b got %b want %b", c, rerr, (m > 33));
            end
        end
    endtask

    task automatic test_reset_mid_acc;
        int data, lat;
        logic rerr;
        bit ok;
        wait_ready(0, ok);
        code_a = 8'b11111111;
        in_valid_v[0] = 1'b1;
        @(posedge clock); #1;
        in_valid_v[0] = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        vectors += 4;
        if (out_valid_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_out_valid got %b want 0", out_valid_v[0]);
        end
        if (in_ready_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_in_ready got %b want 1", in_ready_v[0]);
        end
        if (dout_a !== 6'd0) begin
            miscompares++;
            $display("FAIL midreset_dataout got %0d want 0", dout_a);
        end
        if (busy_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_busy got %b want 0", busy_v[0]);
        end
        xfer(0, 16'h0003, 0, data, rerr, lat, ok);
        vectors += 2;
        if (data !== 2) begin
            miscompares++;
            $display("FAIL midreset_next got %0d want 2", data);
        end
        if (lat !== 8) begin
            miscompares++;
            $display("FAIL midreset_latency got %0d want 8", lat);
        end
    endtask

    task automatic test_sweep_cw4;
        int data, lat, m;
        logic rerr;
        bit ok;
        for (int c = 0; c < 16; c++) begin
            m = fns_value(4, 16'(c));
            xfer(2, 16'(c), 0, data, rerr, lat, ok);
            vectors += 3;
            if (data !== m) begin
                miscompares++;
                $display("FAIL cw4_value code %0d got %0d want %0d", c, data, m);
            end
            if (lat !== 4) begin
                miscompares++;
                $display("FAIL cw4_latency code %0d got %0d want 4", c, lat);
            end
            if (rerr !== 1'b0) begin
                miscompares++;
                $display("FAIL cw4_range_err code %0d got %b want 0", c, rerr);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] c;
        int data, lat, m;
        logic rerr;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            c = 8'($urandom_range(0, 255));
            m = fns_value(8, {8'h00, c});
            xfer(0, {8'h00, c}, int'($urandom_range(0, 3)), data, rerr, lat, ok);
            vectors += 4;
            if (data !== m) begin
                miscompares++;
                $display("FAIL rand_value code %b got %0d want %0d", c, data, m);
            end
            if (lat !== 8) begin
                miscompares++;
                $display("FAIL rand_latency code %b got %0d want 8", c, lat);
            end
            if (rerr !== (m > 54)) begin
                miscompares++;
                $display("FAIL rand_range_err code %b got %b want %b", c, rerr, (m > 54));
            end
            if (int'(dout_a) !== m) begin
                miscompares++;
                $display("FAIL rand_hold code %b got %0d want %0d", c, dout_a, m);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_valid_v  = '0;
        out_ready_v = '0;
        code_a      = '0;
        code_b      = '0;
        code_c      = '0;
        test_reset();
        test_decode();
        test_back_to_back();
        test_backpressure();
        test_range();
        test_reset_mid_acc();
        test_sweep_cw4();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
